// File: rtl/cmp_multicycle.sv
// cmp_multicycle - multicycle signed/equality comparator, CHUNK bits per cycle LSB first.
// Equality accumulates per-chunk XOR; less-than comes from a rippled a + ~b + 1.
module cmp_multicycle #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_data_a,
  input  logic [WIDTH-1:0] i_data_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_is_equal,
  output logic             o_is_less_than
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [CW-1:0]    r_count;
  logic             r_carry;
  logic             r_neq;
  logic             r_eq;
  logic             r_lt;

  logic             w_accept;
  logic             w_last;
  logic             w_cout;
  logic             w_s;
  logic             w_neq;
  logic             w_v;

  assign w_accept = i_start && (r_state != ST_RUN);
  assign w_last   = (r_count == LAST);

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_next = ST_RUN;
      ST_RUN:  if (w_last)  w_next = ST_DONE;
      ST_DONE: w_next = i_start ? ST_RUN : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // One chunk of a + ~b + carry; only the top diff bit and carry-out are needed.
  always_comb begin
    w_cout = r_carry;
    w_s    = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      w_s    = r_a[i] ^ ~r_b[i] ^ w_cout;
      w_cout = (r_a[i] & ~r_b[i]) | (w_cout & (r_a[i] ^ ~r_b[i]));
    end
  end

  assign w_neq = r_neq | (|(r_a[CHUNK-1:0] ^ r_b[CHUNK-1:0]));
  assign w_v   = (r_a_msb != r_b_msb) & (w_s != r_a_msb);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_count <= '0;
      r_carry <= 1'b1;
      r_neq   <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= i_data_a;
      r_b     <= i_data_b;
      r_a_msb <= i_data_a[WIDTH-1];
      r_b_msb <= i_data_b[WIDTH-1];
      r_count <= '0;
      r_carry <= 1'b1;
      r_neq   <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_a     <= r_a >> CHUNK;
      r_b     <= r_b >> CHUNK;
      r_count <= r_count + 1'b1;
      r_carry <= w_cout;
      r_neq   <= w_neq;
      if (w_last) begin
        r_eq <= ~w_neq;
        r_lt <= w_s ^ w_v;
      end
    end
  end

  assign o_busy         = (r_state == ST_RUN);
  assign o_done         = (r_state == ST_DONE);
  assign o_is_equal     = r_eq;
  assign o_is_less_than = r_lt;

endmodule

// File: tb/tb_cmp_multicycle.sv
// tb_cmp_multicycle - directed and random compares checked against signed/equality arithmetic.
module tb_cmp_multicycle;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] da = '0;
  logic [31:0] db = '0;
  logic        busy, done, eq, lt;
  int          total = 0;
  int          bad = 0;

  cmp_multicycle #(.WIDTH(32), .CHUNK(4)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start),
    .i_data_a(da), .i_data_b(db),
    .o_busy(busy), .o_done(done),
    .o_is_equal(eq), .o_is_less_than(lt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_lt(input logic [31:0] a, input logic [31:0] b);
    return $signed(a) < $signed(b);
  endfunction

  // Caller sits at a negedge after the accept edge; counts busy cycles until done.
  task automatic wait_done(input string tag, input bit poke, output int nbusy, output bit seen);
    nbusy = 0;
    seen  = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) nbusy++;
      if (poke) begin
        start = (i == 2);
        da    = $urandom;
        db    = $urandom;
      end
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_latency"}, nbusy, 8);
  endtask

  task automatic run_cmp(input logic [31:0] a, input logic [31:0] b, input string tag);
    int nbusy;
    bit seen;
    logic e_eq, e_lt;
    e_eq = (a == b);
    e_lt = ref_lt(a, b);
    @(negedge clk);
    start = 1'b1;
    da    = a;
    db    = b;
    @(negedge clk);
    start = 1'b0;
    da    = ~a;
    db    = ~b;
    wait_done(tag, 1'b1, nbusy, seen);
    start = 1'b0;
    chk({tag, "_eq"}, eq, e_eq);
    chk({tag, "_lt"}, lt, e_lt);
    chk({tag, "_busy_at_done"}, busy, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_eq_hold"}, eq, e_eq);
    chk({tag, "_lt_hold"}, lt, e_lt);
  endtask

  initial begin
    logic [31:0] ops_a[6];
    logic [31:0] ops_b[6];
    int          nbusy;
    bit          seen;
    int          ndone;
    logic [31:0] ra, rb;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_eq", eq, 0);
    chk("reset_lt", lt, 0);
    rst = 1'b0;

    run_cmp(32'h0000_1234, 32'h0000_1234, "equal");
    run_cmp(32'hFFFF_FFFF, 32'h0000_0001, "neg1_vs_1");
    run_cmp(32'h0000_0001, 32'hFFFF_FFFF, "1_vs_neg1");
    run_cmp(32'h8000_0000, 32'h7FFF_FFFF, "min_vs_max");
    run_cmp(32'h7FFF_FFFF, 32'h8000_0000, "max_vs_min");
    run_cmp(32'h0000_0000, 32'h8000_0000, "zero_vs_min");
    run_cmp(32'h0000_0000, 32'h0000_0001, "bit0_diff");
    run_cmp(32'h0000_0000, 32'h8000_0000, "bit31_diff");

    for (int k = 0; k < 16; k++) begin
      ra = $urandom;
      rb = (k % 4 == 0) ? ra : (k % 4 == 1) ? (ra ^ (32'h1 << $urandom_range(31, 0))) : $urandom;
      run_cmp(ra, rb, $sformatf("rand%0d", k));
    end

    // start held high: DONE goes straight back to RUN with the next operands
    for (int j = 0; j < 6; j++) begin
      ops_a[j] = $urandom;
      ops_b[j] = (j == 2) ? ops_a[j] : $urandom;
    end
    @(negedge clk);
    start = 1'b1;
    da    = ops_a[0];
    db    = ops_b[0];
    @(negedge clk);
    for (int j = 0; j < 6; j++) begin
      da = $urandom;
      db = $urandom;
      wait_done($sformatf("b2b%0d", j), 1'b0, nbusy, seen);
      chk($sformatf("b2b%0d_eq", j), eq, (ops_a[j] == ops_b[j]));
      chk($sformatf("b2b%0d_lt", j), lt, ref_lt(ops_a[j], ops_b[j]));
      if (j < 5) begin
        da = ops_a[j+1];
        db = ops_b[j+1];
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("b2b%0d_restart_busy", j), busy, (j < 5));
    end

    // abort mid-RUN after three chunks; flags set by a prior equal compare must clear
    run_cmp(32'hCAFE_0001, 32'hCAFE_0001, "pre_abort");
    @(negedge clk);
    start = 1'b1;
    da    = 32'h8000_0000;
    db    = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_eq", eq, 0);
    chk("abort_lt", lt, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", ndone, 0);
    run_cmp(32'h8000_0000, 32'h0000_0001, "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
